display_frame_sequencer: RTL and testbench

//  Frame-level controller for the display DataPath. Latches a frame geometry (HB/VB blanking,
//  AIP active pixels/line, AIL active lines), writes it to the datapath, then sequences

---
 rtl/display_frame_sequencer_if.sv | 32 +++
 rtl/display_frame_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_display_frame_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// display_frame_sequencer_if
//   Pixel-source handshake between the image source (file reader) and the
//   frame sequencer. A word moves on every clock edge where pix_valid and
//   pix_ready are both high.
//
//   pix_valid  source -> sequencer   source has a word on pix_data
//   pix_data   source -> sequencer   pixel word (DATA_W bits)
//   pix_ready  sequencer -> source   sequencer accepts pix_data this cycle
//
//   master : the image source
//   slave  : the frame sequencer
// ---------------------------------------------------------------------------
interface display_frame_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;

    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready
    );
endinterface

// File: rtl/display_frame_sequencer.sv
// ---------------------------------------------------------------------------
// display_frame_sequencer
//   Frame-level controller for the display DataPath. On start it captures a
//   frame geometry, publishes it to the DataPath with a one-cycle cfg_wr, then
//   walks vertical blanking, and per line horizontal blanking followed by the
//   active interval. During active intervals pixel words are pulled from the
//   source handshake and presented on WData qualified by CSDisplay.
//
//   clk, reset                  clock, synchronous active-high reset
//   start                       request one frame (honoured only in IDLE)
//   cfg_hb/vb/aip/ail           requested geometry
//   pix (slave)                 pixel source handshake
//   WData, CSDisplay            pixel word and its qualifier to DataPath
//   HBOut/VBOut/AIPOut/AILOut   geometry in use, valid from cfg_wr onward
//   cfg_wr                      pulse: geometry outputs newly valid
//   busy                        high in every state except IDLE
//   frame_done                  pulse coinciding with the last CSDisplay
//   cfg_err                     pulse: start rejected (zero aip or ail)
//   frame_count                 completed frames, wraps at 255
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | waiting for start
//   S_LOAD   | geometry outputs valid, cfg_wr high
//   S_VBLANK | vertical blanking, VB cycles once per frame
//   S_HBLANK | horizontal blanking, HB cycles before every line
//   S_ACTIVE | pix_ready high, one word per transfer until AIP words taken
//   S_DONE   | frame_done high for one cycle
// ---------------------------------------------------------------------------
module display_frame_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     cfg_hb,
    input  logic [CNT_W-1:0]     cfg_vb,
    input  logic [CNT_W-1:0]     cfg_aip,
    input  logic [CNT_W-1:0]     cfg_ail,
    display_frame_sequencer_if.slave pix,
    output logic [DATA_W-1:0]    WData,
    output logic                 CSDisplay,
    output logic [CNT_W-1:0]     HBOut,
    output logic [CNT_W-1:0]     VBOut,
    output logic [CNT_W-1:0]     AIPOut,
    output logic [CNT_W-1:0]     AILOut,
    output logic                 cfg_wr,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 cfg_err,
    output logic [7:0]           frame_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VBLANK = 3'd2,
        S_HBLANK = 3'd3,
        S_ACTIVE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t              state_q,       state_d;
    logic [CNT_W-1:0]    blank_cnt_q,   blank_cnt_d;
    logic [CNT_W-1:0]    pix_cnt_q,     pix_cnt_d;
    logic [CNT_W-1:0]    line_cnt_q,    line_cnt_d;
    logic [CNT_W-1:0]    hb_q,          hb_d;
    logic [CNT_W-1:0]    vb_q,          vb_d;
    logic [CNT_W-1:0]    aip_q,         aip_d;
    logic [CNT_W-1:0]    ail_q,         ail_d;
    logic [DATA_W-1:0]   wdata_q,       wdata_d;
    logic                cs_q,          cs_d;
    logic                cfg_wr_q,      cfg_wr_d;
    logic                busy_q,        busy_d;
    logic                frame_done_q,  frame_done_d;
    logic                cfg_err_q,     cfg_err_d;
    logic [7:0]          frame_count_q, frame_count_d;

    logic                xfer;
    state_t              after_vblank;

    // pix_ready is a pure state decode so the source never sees a
    // combinational path from its own pix_valid.
    assign pix.pix_ready = (state_q == S_ACTIVE);
    assign xfer          = pix.pix_valid && (state_q == S_ACTIVE);

    // A zero HB skips horizontal blanking entirely, including before line 0.
    assign after_vblank  = (hb_q != CNT_ZERO) ? S_HBLANK : S_ACTIVE;

    always_comb begin
        state_d       = state_q;
        blank_cnt_d   = blank_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        hb_d          = hb_q;
        vb_d          = vb_q;
        aip_d         = aip_q;
        ail_d         = ail_q;
        wdata_d       = wdata_q;
        cs_d          = 1'b0;
        cfg_wr_d      = 1'b0;
        frame_done_d  = 1'b0;
        cfg_err_d     = 1'b0;
        frame_count_d = frame_count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((cfg_aip != CNT_ZERO) && (cfg_ail != CNT_ZERO)) begin
                        // Geometry registers double as the DataPath outputs,
                        // so they become visible together with cfg_wr in LOAD.
                        hb_d     = cfg_hb;
                        vb_d     = cfg_vb;
                        aip_d    = cfg_aip;
                        ail_d    = cfg_ail;
                        cfg_wr_d = 1'b1;
                        state_d  = S_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                blank_cnt_d = CNT_ZERO;
                pix_cnt_d   = CNT_ZERO;
                line_cnt_d  = CNT_ZERO;
                state_d     = (vb_q != CNT_ZERO) ? S_VBLANK : after_vblank;
            end

            S_VBLANK: begin
                if (blank_cnt_q == vb_q - CNT_ONE) begin
                    blank_cnt_d = CNT_ZERO;
                    state_d     = after_vblank;
                end else begin
                    blank_cnt_d = blank_cnt_q + CNT_ONE;
                end
            end

            S_HBLANK: begin
                if (blank_cnt_q == hb_q - CNT_ONE) begin
                    blank_cnt_d = CNT_ZERO;
                    state_d     = S_ACTIVE;
                end else begin
                    blank_cnt_d = blank_cnt_q + CNT_ONE;
                end
            end

            S_ACTIVE: begin
                if (xfer) begin
                    wdata_d = pix.pix_data;
                    cs_d    = 1'b1;
                    if (pix_cnt_q == aip_q - CNT_ONE) begin
                        pix_cnt_d = CNT_ZERO;
                        if (line_cnt_q == ail_q - CNT_ONE) begin
                            // frame_done lands in the same cycle as the
                            // final CSDisplay pulse.
                            frame_done_d  = 1'b1;
                            frame_count_d = frame_count_q + 8'd1;
                            state_d       = S_DONE;
                        end else begin
                            line_cnt_d = line_cnt_q + CNT_ONE;
                            state_d    = (hb_q != CNT_ZERO) ? S_HBLANK : S_ACTIVE;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + CNT_ONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            blank_cnt_q   <= '0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            hb_q          <= '0;
            vb_q          <= '0;
            aip_q         <= '0;
            ail_q         <= '0;
            wdata_q       <= '0;
            cs_q          <= 1'b0;
            cfg_wr_q      <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            blank_cnt_q   <= blank_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            hb_q          <= hb_d;
            vb_q          <= vb_d;
            aip_q         <= aip_d;
            ail_q         <= ail_d;
            wdata_q       <= wdata_d;
            cs_q          <= cs_d;
            cfg_wr_q      <= cfg_wr_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            cfg_err_q     <= cfg_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign WData       = wdata_q;
    assign CSDisplay   = cs_q;
    assign HBOut       = hb_q;
    assign VBOut       = vb_q;
    assign AIPOut      = aip_q;
    assign AILOut      = ail_q;
    assign cfg_wr      = cfg_wr_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign cfg_err     = cfg_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_display_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_display_frame_sequencer
//   Directed bench for display_frame_sequencer. Each frame run logs one sample
//   per cycle (taken on the falling edge) and is then checked against
//   hand-derived cycle positions and handshake rules.
// ---------------------------------------------------------------------------
module tb_display_frame_sequencer;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 10;
    localparam int NLOG   = 64;

    logic               clk;
    logic               reset;
    logic               start;
    logic [CNT_W-1:0]   cfg_hb, cfg_vb, cfg_aip, cfg_ail;
    logic [DATA_W-1:0]  WData;
    logic               CSDisplay;
    logic [CNT_W-1:0]   HBOut, VBOut, AIPOut, AILOut;
    logic               cfg_wr, busy, frame_done, cfg_err;
    logic [7:0]         frame_count;

    display_frame_sequencer_if #(.DATA_W(DATA_W)) pif ();

    display_frame_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_hb      (cfg_hb),
        .cfg_vb      (cfg_vb),
        .cfg_aip     (cfg_aip),
        .cfg_ail     (cfg_ail),
        .pix         (pif),
        .WData       (WData),
        .CSDisplay   (CSDisplay),
        .HBOut       (HBOut),
        .VBOut       (VBOut),
        .AIPOut      (AIPOut),
        .AILOut      (AILOut),
        .cfg_wr      (cfg_wr),
        .busy        (busy),
        .frame_done  (frame_done),
        .cfg_err     (cfg_err),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] src_cnt;
    logic [63:0] stall_pat;

    logic        log_cs   [NLOG];
    logic [31:0] log_wd   [NLOG];
    logic        log_fd   [NLOG];
    logic        log_rdy  [NLOG];
    logic        log_val  [NLOG];
    logic        log_cw   [NLOG];
    logic        log_busy [NLOG];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of source activity; transfer bookkeeping mirrors the handshake
    // rule (word consumed when valid and ready are both high at the edge).
    task automatic tick(input logic v);
        pif.pix_valid = v;
        pif.pix_data  = src_cnt;
        if (v && pif.pix_ready) src_cnt = src_cnt + 32'd1;
        @(negedge clk);
    endtask

    task automatic run_frame(input int hb, input int vb, input int aip, input int ail,
                             input bit random_valid, input int again);
        logic v;
        src_cnt = 32'd0;
        @(negedge clk);
        cfg_hb  = CNT_W'(hb);
        cfg_vb  = CNT_W'(vb);
        cfg_aip = CNT_W'(aip);
        cfg_ail = CNT_W'(ail);
        start   = 1'b1;
        pif.pix_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < NLOG; c++) begin
            log_cs[c]   = CSDisplay;
            log_wd[c]   = WData;
            log_fd[c]   = frame_done;
            log_rdy[c]  = pif.pix_ready;
            log_cw[c]   = cfg_wr;
            log_busy[c] = busy;
            if (c == again) begin
                start   = 1'b1;
                cfg_aip = CNT_W'(1);
            end else begin
                start = 1'b0;
            end
            v = random_valid ? stall_pat[c] : 1'b1;
            log_val[c] = v;
            tick(v);
        end
        pif.pix_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int npix);
        int ncs    = 0;
        int nfd    = 0;
        int wd_err = 0;
        int hs_err = 0;
        int last_cs = -1;
        int fd_cyc  = -2;
        for (int c = 0; c < NLOG; c++) begin
            if (log_cs[c]) begin
                if (log_wd[c] !== 32'(ncs)) wd_err++;
                ncs++;
                last_cs = c;
            end
            if (log_fd[c]) begin
                nfd++;
                fd_cyc = c;
            end
            if (c > 0 && log_cs[c] !== (log_rdy[c-1] && log_val[c-1])) hs_err++;
        end
        chk({tag, "_cs_count"},   32'(ncs),    32'(npix));
        chk({tag, "_wdata_order"}, 32'(wd_err), 32'd0);
        chk({tag, "_done_count"}, 32'(nfd),    32'd1);
        chk({tag, "_done_at_last_cs"}, 32'(fd_cyc), 32'(last_cs));
        chk({tag, "_handshake"},  32'(hs_err), 32'd0);
    endtask

    initial begin
        logic [31:0] m_cs, m_rdy;

        reset   = 1'b1;
        start   = 1'b0;
        cfg_hb  = '0;
        cfg_vb  = '0;
        cfg_aip = '0;
        cfg_ail = '0;
        pif.pix_valid = 1'b0;
        pif.pix_data  = '0;
        src_cnt   = 32'd0;
        stall_pat = 64'hD6B5_6DA3_5B6D_AD5B;
        repeat (3) @(negedge clk);

        chk("rst_cs",    32'(CSDisplay),   32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_ready", 32'(pif.pix_ready), 32'd0);
        chk("rst_fcnt",  32'(frame_count), 32'd0);
        chk("rst_hb",    32'(HBOut),       32'd0);
        reset = 1'b0;

        // 1: hb=2 vb=3 aip=4 ail=2, source always valid.
        // LOAD c0, VBLANK c1-3, HBLANK c4-5, ACTIVE c6-9, HBLANK c10-11,
        // ACTIVE c12-15, DONE c16 (CSDisplay c7-10 and c13-16).
        run_frame(2, 3, 4, 2, 1'b0, -1);
        m_cs = '0;
        m_rdy = '0;
        for (int c = 0; c < 32; c++) begin
            m_cs[c]  = log_cs[c];
            m_rdy[c] = log_rdy[c];
        end
        chk("t1_cfg_wr_c0",  32'(log_cw[0]),   32'd1);
        chk("t1_cfg_wr_c1",  32'(log_cw[1]),   32'd0);
        chk("t1_busy_c0",    32'(log_busy[0]), 32'd1);
        chk("t1_busy_c17",   32'(log_busy[17]), 32'd0);
        chk("t1_ready_mask", m_rdy,            32'h0000_F3C0);
        chk("t1_cs_mask",    m_cs,             32'h0001_E780);
        chk("t1_done_c16",   32'(log_fd[16]),  32'd1);
        check_frame("t1", 8);
        chk("t1_fcnt",  32'(frame_count), 32'd1);
        chk("t1_hbout", 32'(HBOut),  32'd2);
        chk("t1_vbout", 32'(VBOut),  32'd3);
        chk("t1_aipout", 32'(AIPOut), 32'd4);
        chk("t1_ailout", 32'(AILOut), 32'd2);

        // 2: same geometry, source valid follows a fixed stall pattern.
        run_frame(2, 3, 4, 2, 1'b1, -1);
        check_frame("t2", 8);
        chk("t2_fcnt", 32'(frame_count), 32'd2);

        // 3: no blanking; ACTIVE c1-6, six back-to-back CSDisplay c2-7.
        run_frame(0, 0, 3, 2, 1'b0, -1);
        m_cs = '0;
        m_rdy = '0;
        for (int c = 0; c < 32; c++) begin
            m_cs[c]  = log_cs[c];
            m_rdy[c] = log_rdy[c];
        end
        chk("t3_ready_mask", m_rdy, 32'h0000_007E);
        chk("t3_cs_mask",    m_cs,  32'h0000_00FC);
        chk("t3_done_c7",    32'(log_fd[7]), 32'd1);
        check_frame("t3", 6);
        chk("t3_fcnt", 32'(frame_count), 32'd3);

        // 4: rejected starts leave the published geometry alone.
        @(negedge clk);
        cfg_hb = 10'd7; cfg_vb = 10'd7; cfg_aip = 10'd0; cfg_ail = 10'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4a_cfg_err", 32'(cfg_err), 32'd1);
        chk("t4a_busy",    32'(busy),    32'd0);
        chk("t4a_cfg_wr",  32'(cfg_wr),  32'd0);
        chk("t4a_aipout",  32'(AIPOut),  32'd3);
        chk("t4a_ailout",  32'(AILOut),  32'd2);
        chk("t4a_hbout",   32'(HBOut),   32'd0);
        @(negedge clk);
        chk("t4a_err_pulse", 32'(cfg_err), 32'd0);
        cfg_aip = 10'd5; cfg_ail = 10'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4b_cfg_err", 32'(cfg_err), 32'd1);
        chk("t4b_busy",    32'(busy),    32'd0);
        chk("t4b_aipout",  32'(AIPOut),  32'd3);
        chk("t4b_vbout",   32'(VBOut),   32'd0);
        @(negedge clk);
        chk("t4b_err_pulse", 32'(cfg_err), 32'd0);
        chk("t4b_busy_idle", 32'(busy),    32'd0);

        // 5: reset in the second active line (cycle 13), then a full frame.
        src_cnt = 32'd0;
        cfg_hb = 10'd2; cfg_vb = 10'd3; cfg_aip = 10'd4; cfg_ail = 10'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) tick(1'b1);
        chk("t5_pre_busy", 32'(busy),  32'd1);
        chk("t5_pre_ready", 32'(pif.pix_ready), 32'd1);
        reset = 1'b1;
        tick(1'b1);
        chk("t5_rst_cs",    32'(CSDisplay),   32'd0);
        chk("t5_rst_wdata", WData,            32'd0);
        chk("t5_rst_busy",  32'(busy),        32'd0);
        chk("t5_rst_ready", 32'(pif.pix_ready), 32'd0);
        chk("t5_rst_fcnt",  32'(frame_count), 32'd0);
        chk("t5_rst_aip",   32'(AIPOut),      32'd0);
        reset = 1'b0;
        pif.pix_valid = 1'b0;
        run_frame(2, 3, 4, 2, 1'b0, -1);
        check_frame("t5", 8);
        chk("t5_fcnt", 32'(frame_count), 32'd1);

        // 6: start pulsed mid-frame (with a different aip) is ignored;
        // two frames back to back from a fresh reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_frame(2, 3, 4, 2, 1'b0, 8);
        check_frame("t6a", 8);
        chk("t6a_aipout", 32'(AIPOut), 32'd4);
        chk("t6a_fcnt",   32'(frame_count), 32'd1);
        run_frame(2, 3, 4, 2, 1'b0, -1);
        check_frame("t6b", 8);
        chk("t6_fcnt", 32'(frame_count), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
